// File: rtl/fetch_pkg.sv
// Shared definitions for the k11 instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned DEPTH_DEFAULT    = 2;

    // One buffered instruction as presented to decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and a registered head.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic [WIDTH-1:0] r_head;

    logic             w_do_pop;
    logic [PTR_W-1:0] w_wr_inc;
    logic [PTR_W-1:0] w_rd_inc;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_count_next;

    assign w_do_pop     = i_pop & (r_count != '0);
    assign w_wr_inc     = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_inc     = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
    assign w_rd_next    = w_do_pop ? w_rd_inc : r_rd_ptr;
    assign w_count_next = r_count + CNT_W'(i_push) - CNT_W'(w_do_pop);

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Head is precomputed so the consumer sees a flop, not the storage mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= i_push ? w_wr_inc : r_wr_ptr;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            if (w_count_next != '0) begin
                r_head <= (i_push && (r_wr_ptr == w_rd_next)) ? i_data : r_mem[w_rd_next];
            end
        end
    end

    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_data  = r_head;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: owns the PC, issues credited word reads and buffers
// returned instructions for decode; a redirect flushes and drops stale data.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_ro,
    input  logic        ready_i,
    output logic [31:0] pc_ro,
    output logic [31:0] inst_ro
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = $bits(fetch_entry_t);

    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [CNT_W-1:0] w_outstanding;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] w_out_next;
    logic             w_gnt;
    logic             w_keep;
    logic             w_pcq_valid;
    logic [31:0]      w_pcq_pc;
    logic             w_out_valid;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    // A request only goes out when its response is guaranteed a FIFO slot.
    assign imem_req_o  = ~rst & ~redirect_i &
                         ((SUM_W'(w_outstanding) + SUM_W'(w_fifo_count)) < SUM_W'(DEPTH));
    assign imem_addr_o = r_fetch_pc;

    assign w_gnt        = imem_gnt_i & imem_req_o;
    assign w_keep       = imem_rvalid_i & (r_drop_cnt == '0) & ~redirect_i;
    assign w_out_next   = w_outstanding + CNT_W'(w_gnt) - CNT_W'(imem_rvalid_i);
    assign w_push_entry = '{pc: w_pcq_pc, inst: imem_rdata_i};

    // PCs of granted requests; its occupancy is the outstanding count.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_gnt),
        .i_pop   (imem_rvalid_i),
        .i_flush (1'b0),
        .i_data  (r_fetch_pc),
        .o_count (w_outstanding),
        .o_valid (w_pcq_valid),
        .o_data  (w_pcq_pc)
    );

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_keep),
        .i_pop   (ready_i & ~redirect_i),
        .i_flush (redirect_i),
        .i_data  (w_push_entry),
        .o_count (w_fifo_count),
        .o_valid (w_out_valid),
        .o_data  (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_fetch_pc <= word_align(redirect_pc_i);
        end else if (w_gnt) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Everything still in flight at a redirect belongs to the old path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (redirect_i) begin
            r_drop_cnt <= w_out_next;
        end else if (imem_rvalid_i && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        end
    end

    assign valid_ro = w_out_valid;
    assign pc_ro    = w_head.pc;
    assign inst_ro  = w_head.inst;

    a_gnt_needs_req: assert property (@(posedge clk) disable iff (rst)
        imem_gnt_i |-> imem_req_o);
    a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> w_pcq_valid);

endmodule
